dm_load_unit: RTL
=================

// Module: dm_load_unit
// PURPOSE
//  Read-side companion to the byte-addressed 4 KB data memory. Accepts load requests
//  (lb/lbu/lh/lhu/lw) from the pipeline MEM stage. Drives the memory's word read port
//  and returns the aligned, sign/zero-extended result through a valid/ready handshake.
//  Loads that cross a word boundary take two word reads, merged internally.
//  busy stalls the pipeline while a load is in flight.
// PARAMETERS
//  ADDR_W   12   byte address width; word index = addr[ADDR_W-1:2]
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous, active-low reset
//  req_valid  in   1        load request valid
//  req_ready  out  1        unit can accept a request (1 only in IDLE)
//  req_addr   in   ADDR_W   byte address of load
//  req_type   in   3        000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others invalid
//  mem_addr   out  ADDR_W   byte address to memory; bits[1:0] always 00
//  mem_rdata  in   32       combinational read data for mem_addr (same cycle)
//  rsp_valid  out  1        result valid
//  rsp_ready  in   1        consumer takes result
//  rsp_data   out  32       extended load result
//  rsp_err    out  1        1 = invalid req_type (rsp_data = 0)
//  busy       out  1        ~req_ready; pipeline stall
// BEHAVIOUR
//  - Byte lanes are little-endian, matching the store path: the byte at addr[1:0]=n is in bits [8n+7:8n].
//  - States: IDLE -> RD0 -> (RD1 if crossing) -> RESP -> IDLE.
//  - IDLE: req_ready=1. On req_valid&req_ready (cycle T), latch addr, type and err; go to RD0.
//  - RD0 (T+1): mem_addr = {addr[ADDR_W-1:2],2'b00}. Register mem_rdata as w0 at clock edge.
//    Crossing = (LH/LHU & addr[1:0]==11) | (LW & addr[1:0]!=00). If crossing, go to RD1; else go to RESP.
//  - RD1 (T+2): mem_addr = next word. The word index wraps within the memory (last word -> 0).
//    Register mem_rdata as w1, then go to RESP.
//  - RESP: rsp_valid=1. rsp_data and rsp_err are registered and stable until rsp_ready.
//    On rsp_valid&rsp_ready, go to IDLE. A new request is accepted no earlier than the next cycle.
//  - Latency (accept to rsp_valid): 2 cycles aligned, 3 cycles crossing. Throughput: 1 load per 3 or 4 cycles.
//  - Merge: bytes = {w1,w0} >> (8*addr[1:0]); take the low 8/16/32 bits by size.
//  - Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the 32 bits.
//  - Invalid type: single read, no crossing. rsp_err=1, rsp_data=32'h0.
//  - In IDLE and RESP, mem_addr holds its last value. Memory is read-only from this unit.
//  - req_addr/req_type are sampled only at acceptance. Later changes have no effect.
//  - rst_n low, at any time including mid-load: async return to IDLE.
//    rsp_valid=0, rsp_data=0, rsp_err=0, mem_addr=0, w0=w1=0.
//    req_ready=1 and busy=0 while in reset. An in-flight load is discarded and no response is produced.
// TESTING
//  1. RAM[4]=32'hDEADBEEF; LW @0x010 accepted at T -> rsp_valid at T+2, rsp_data=32'hDEADBEEF, err=0.
//  2. RAM[4]=32'h80000000; LB @0x013 -> 32'hFFFFFF80; LBU @0x013 -> 32'h00000080.
//  3. RAM[4]=32'h12000000, RAM[5]=32'h00000034; LHU @0x013 -> mem_addr 0x010 then 0x014;
//     rsp at T+3 = 32'h00003412; LH gives the same value.
//  4. Wrap: RAM[1023]=32'hAABBCCDD, RAM[0]=32'h11223344; LW @0xFFE -> mem_addr 0xFFC then 0x000;
//     rsp_data=32'h3344AABB.
//  5. Backpressure: hold rsp_ready=0 for 3 cycles in RESP -> rsp_valid, rsp_data and busy stay 1/stable;
//     req_valid is ignored; the handshake on the 4th cycle returns to IDLE.
//  6. Reset/invalid: assert rst_n=0 during RD1 -> outputs zero at once; the next LW is served normally.
//     req_type=3'b111 -> rsp_err=1, rsp_data=0.

Source files
------------

// File: rtl/dm_load_if.sv
// Load-unit bus bundle: pipeline request/response handshake plus the word read port to data memory.
// The master side is the pipeline and the memory; the slave side is the load unit.
interface dm_load_if #(parameter int ADDR_W = 12);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_type;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_err;
  logic              busy;

  modport master (
    output req_valid, req_addr, req_type, rsp_ready, mem_rdata,
    input  req_ready, mem_addr, rsp_valid, rsp_data, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_addr, req_type, rsp_ready, mem_rdata,
    output req_ready, mem_addr, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/dm_load_unit.sv
// Data-memory load unit: reads one or two words, merges them little-endian and
// returns the sign/zero-extended byte, half or word through a valid/ready handshake.
module dm_load_unit #(
  parameter int ADDR_W = 12
) (
  input logic     clk,
  input logic     rst_n,
  dm_load_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD0, RD1, RESP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        ltype;
  logic              err;
  logic [31:0]       w0;
  logic [31:0]       w1;
  logic [ADDR_W-3:0] next_idx;
  logic              crossing;

  function automatic logic is_invalid(input logic [2:0] t);
    logic r;
    case (t)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: r = 1'b0;
      default:                                r = 1'b1;
    endcase
    return r;
  endfunction

  // pair is {upper word, lower word}; the load starts at byte offset off of the lower word
  function automatic logic [31:0] extract_load(input logic [63:0] pair, input logic [1:0] off,
                                               input logic [2:0] t, input logic e);
    logic [31:0] sh;
    logic [31:0] r;
    sh = 32'(pair >> {off, 3'b000});
    r  = 32'h0;
    if (!e) begin
      case (t)
        3'b000:  r = {{24{sh[7]}}, sh[7:0]};
        3'b001:  r = {{16{sh[15]}}, sh[15:0]};
        3'b010:  r = sh;
        3'b100:  r = {24'h0, sh[7:0]};
        3'b101:  r = {16'h0, sh[15:0]};
        default: r = 32'h0;
      endcase
    end
    return r;
  endfunction

  assign next_idx      = addr[ADDR_W-1:2] + (ADDR_W-2)'(1);
  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);

  // Invalid types never cross, so they always complete with a single read
  always_comb begin
    crossing = 1'b0;
    if (!err) begin
      case (ltype[1:0])
        2'b01:   crossing = (addr[1:0] == 2'b11);
        2'b10:   crossing = (addr[1:0] != 2'b00);
        default: crossing = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      addr          <= '0;
      ltype         <= 3'b000;
      err           <= 1'b0;
      w0            <= 32'h0;
      w1            <= 32'h0;
      bus.mem_addr  <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= 32'h0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr         <= bus.req_addr;
            ltype        <= bus.req_type;
            err          <= is_invalid(bus.req_type);
            bus.mem_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            state        <= RD0;
          end
        end
        RD0: begin
          w0 <= bus.mem_rdata;
          if (crossing) begin
            bus.mem_addr <= {next_idx, 2'b00};
            state        <= RD1;
          end else begin
            bus.rsp_data  <= extract_load({w1, bus.mem_rdata}, addr[1:0], ltype, err);
            bus.rsp_err   <= err;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end
        end
        RD1: begin
          w1            <= bus.mem_rdata;
          bus.rsp_data  <= extract_load({bus.mem_rdata, w0}, addr[1:0], ltype, err);
          bus.rsp_err   <= err;
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
